// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Brief    : Shared binary32 types, constants and helpers for the FPU datapath
// Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int          EXP_W        = 8;
    localparam int          FRAC_W       = 23;
    localparam int          BIAS         = 127;
    localparam logic [31:0] QNAN_DEFAULT = 32'hFFC00000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float32_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        SUB  = 3'd1,
        NORM = 3'd2,
        INF  = 3'd3,
        NAN  = 3'd4
    } fclass_e;

    // Operand class from the exponent / fraction fields
    function automatic fclass_e classify(input float32_t f);
        fclass_e c;
        if (f.exp == '0)
            c = (f.frac == '0) ? ZERO : SUB;
        else if (f.exp == '1)
            c = (f.frac == '0) ? INF : NAN;
        else
            c = NORM;
        return c;
    endfunction

    // Leading-zero count of a 48-bit product (48 when all zero)
    function automatic logic [5:0] clz48(input logic [47:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd0;
        found = 1'b0;
        for (int i = 47; i >= 0; i--) begin
            if (!found) begin
                if (v[i])
                    found = 1'b1;
                else
                    n = n + 6'd1;
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmul_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fmul_unit_if
// Brief    : Operand / result bundle of the binary32 multiplier
// Revision : 1.0 - initial release
// ============================================================================
interface fmul_unit_if;
    logic        in_valid;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        out_valid;
    logic [31:0] y;
    logic        ovf;

    modport master (output in_valid, x1, x2, input out_valid, y, ovf);
    modport slave  (input in_valid, x1, x2, output out_valid, y, ovf);
endinterface
`default_nettype wire

// File: rtl/fp_round_norm.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_norm
// Brief    : Normalise, underflow-shift, round-nearest-even and overflow detect
//            for a raw significand product (value = sig/2^46 * 2^(exp_sum-127))
// Revision : 1.0 - initial release
// ============================================================================
module fp_round_norm
    import fpu_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_sum,
    input  logic [47:0]       sig,
    output logic [31:0]       res,
    output logic              ovf
);

    logic [5:0]        lz;
    logic [47:0]       norm;
    logic signed [9:0] exp_n;
    logic [9:0]        shamt;
    logic [47:0]       den;
    logic              lost;
    logic [8:0]        e_base;
    logic              guard;
    logic              rnd;
    logic              sticky;
    logic              inc;
    logic [24:0]       mant;
    logic [33:0]       total;

    // Normalise leading one to bit 47, denormalise on underflow, then round.
    // The encoded result is built as (biased_exp-1)<<23 + significand so a
    // rounding carry walks naturally into the next binade (or out of the
    // subnormal range into the smallest normal).
    always_comb begin
        lz    = clz48(sig);
        norm  = sig << lz;
        exp_n = exp_sum + 10'sd1 - $signed({4'b0000, lz});
        if (exp_n < 10'sd1) begin
            shamt  = 10'sd1 - exp_n;
            den    = norm >> shamt;
            lost   = |(norm & ~({48{1'b1}} << shamt));
            e_base = 9'd0;
        end else begin
            shamt  = 10'd0;
            den    = norm;
            lost   = 1'b0;
            e_base = exp_n[8:0] - 9'd1;
        end
        guard  = den[23];
        rnd    = den[22];
        sticky = (|den[21:0]) | lost;
        inc    = guard & (rnd | sticky | den[24]);
        mant   = {1'b0, den[47:24]} + {24'b0, inc};
        total  = {2'b00, e_base, 23'b0} + {9'b0, mant};
        if (total >= 34'h07F800000) begin
            res = {sign, 8'hFF, 23'h0};
            ovf = 1'b1;
        end else begin
            res = {sign, total[30:0]};
            ovf = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fmul_unit.sv
`default_nettype none
// ============================================================================
// Module   : fmul_unit
// Brief    : Two-stage pipelined IEEE-754 binary32 multiplier (RNE, subnormals)
// Revision : 1.0 - initial release
// ============================================================================
module fmul_unit
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    fmul_unit_if.slave  bus
);

    float32_t          a;
    float32_t          b;
    fclass_e           cls_a;
    fclass_e           cls_b;
    logic              sign_n;
    logic [23:0]       man_a;
    logic [23:0]       man_b;
    logic [7:0]        exp_a;
    logic [7:0]        exp_b;
    logic signed [9:0] exp_sum_n;
    logic [47:0]       prod_n;
    logic              special_n;
    logic [31:0]       spec_y_n;

    logic              s1_valid;
    logic              s1_sign;
    logic signed [9:0] s1_exp;
    logic [47:0]       s1_prod;
    logic              s1_special;
    logic [31:0]       s1_spec_y;

    logic [31:0]       rn_y;
    logic              rn_ovf;

    logic              out_valid_q;
    logic [31:0]       y_q;
    logic              ovf_q;

    assign a = bus.x1;
    assign b = bus.x2;

    // Stage 1: unpack, classify, resolve specials, multiply significands
    always_comb begin
        cls_a     = classify(a);
        cls_b     = classify(b);
        sign_n    = a.sign ^ b.sign;
        man_a     = {a.exp != 8'd0, a.frac};
        man_b     = {b.exp != 8'd0, b.frac};
        exp_a     = (a.exp == 8'd0) ? 8'd1 : a.exp;
        exp_b     = (b.exp == 8'd0) ? 8'd1 : b.exp;
        exp_sum_n = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - $signed(10'(BIAS));
        prod_n    = {24'b0, man_a} * {24'b0, man_b};
        special_n = 1'b1;
        if (cls_a == NAN)
            spec_y_n = {a[31:23], 1'b1, a[21:0]};
        else if (cls_b == NAN)
            spec_y_n = {b[31:23], 1'b1, b[21:0]};
        else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF))
            spec_y_n = QNAN_DEFAULT;
        else if (cls_a == INF || cls_b == INF)
            spec_y_n = {sign_n, 8'hFF, 23'h0};
        else if (cls_a == ZERO || cls_b == ZERO)
            spec_y_n = {sign_n, 31'h0};
        else begin
            spec_y_n  = 32'h0;
            special_n = 1'b0;
        end
    end

    // Stage-1 pipeline register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= 10'sd0;
            s1_prod    <= 48'h0;
            s1_special <= 1'b0;
            s1_spec_y  <= 32'h0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign    <= sign_n;
                s1_exp     <= exp_sum_n;
                s1_prod    <= prod_n;
                s1_special <= special_n;
                s1_spec_y  <= spec_y_n;
            end
        end
    end

    fp_round_norm u_round_norm (
        .sign    (s1_sign),
        .exp_sum (s1_exp),
        .sig     (s1_prod),
        .res     (rn_y),
        .ovf     (rn_ovf)
    );

    // Stage 2: select special or rounded result; hold between valid results
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            y_q         <= 32'h0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                y_q   <= s1_special ? s1_spec_y : rn_y;
                ovf_q <= s1_special ? 1'b0 : rn_ovf;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fmul_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmul_unit
// Brief    : Self-checking bench for fmul_unit against an exact-arithmetic
//            binary32 multiply model
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmul_unit;

    typedef struct {
        int          due;
        logic [31:0] y;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    fmul_unit_if bus ();

    fmul_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Reference: exact integer product m*2^E rounded to the binary32 grid
    task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] ry, output logic rovf);
        logic [7:0]  ea, ebx;
        logic [22:0] fa, fb;
        logic        s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        longint      m, qv, rem, half, bits;
        int          e, p, eb, sh;
        ea = a[30:23]; fa = a[22:0];
        ebx = b[30:23]; fb = b[22:0];
        s      = a[31] ^ b[31];
        nan_a  = (ea == 8'hFF) && (fa != 0);
        nan_b  = (ebx == 8'hFF) && (fb != 0);
        inf_a  = (ea == 8'hFF) && (fa == 0);
        inf_b  = (ebx == 8'hFF) && (fb == 0);
        zero_a = (ea == 8'h00) && (fa == 0);
        zero_b = (ebx == 8'h00) && (fb == 0);
        rovf   = 1'b0;
        if (nan_a) ry = a | 32'h00400000;
        else if (nan_b) ry = b | 32'h00400000;
        else if ((inf_a && zero_b) || (zero_a && inf_b)) ry = 32'hFFC00000;
        else if (inf_a || inf_b) ry = {s, 8'hFF, 23'h0};
        else if (zero_a || zero_b) ry = {s, 31'h0};
        else begin
            m = longint'({ea != 0, fa}) * longint'({ebx != 0, fb});
            e = ((ea == 0) ? 1 : int'(ea)) + ((ebx == 0) ? 1 : int'(ebx)) - 300;
            p = 0;
            for (int i = 0; i < 48; i++) if (m[i]) p = i;
            eb = p + e + 127;
            if (eb < 1) eb = 1;
            sh = (eb - 150) - e;
            if (sh <= 0) qv = m << (-sh);
            else if (sh >= 60) qv = 0;
            else begin
                qv   = m >> sh;
                rem  = m - (qv << sh);
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && qv[0])) qv = qv + 1;
            end
            bits = (longint'(eb - 1) << 23) + qv;
            if (bits >= 64'h7F800000) begin
                ry   = {s, 8'hFF, 23'h0};
                rovf = 1'b1;
            end else begin
                ry = {s, bits[30:0]};
            end
        end
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        v[30:23] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) v[22:0] = 23'h0;
        return v;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ey, input logic eo);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x1       = a;
        bus.x2       = b;
        q.push_back('{cyc + 2, ey, eo});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    // Output monitor: each result must appear exactly on its due cycle
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            check_eq("out_valid", {31'h0, bus.out_valid}, 32'h1);
            check_eq("y", bus.y, q[0].y);
            check_eq("ovf", {31'h0, bus.ovf}, {31'h0, q[0].ovf});
            void'(q.pop_front());
        end else begin
            check_eq("idle_valid", {31'h0, bus.out_valid}, 32'h0);
        end
    end

    logic [31:0] ra, rb, ry;
    logic        ro;

    initial begin
        rstn         = 1'b0;
        bus.in_valid = 1'b0;
        bus.x1       = 32'h0;
        bus.x2       = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", {31'h0, bus.out_valid}, 32'h0);
        check_eq("rst_y", bus.y, 32'h0);
        check_eq("rst_ovf", {31'h0, bus.ovf}, 32'h0);
        rstn = 1'b1;
        idle(2);

        // Directed cases with hand-derived results
        send(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
        idle(3);
        send(32'hBF800000, 32'h40000000, 32'hC0000000, 1'b0);
        send(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b1);
        send(32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFF800000, 1'b1);
        send(32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0);
        send(32'h7F800000, 32'h00000000, 32'hFFC00000, 1'b0);
        send(32'h7FA00000, 32'h3F800000, 32'h7FE00000, 1'b0);
        send(32'h00800000, 32'h3F000000, 32'h00400000, 1'b0);
        send(32'h00000001, 32'h3F000000, 32'h00000000, 1'b0);
        send(32'h00000001, 32'h3FC00000, 32'h00000002, 1'b0);
        send(32'h00400000, 32'h40000000, 32'h00800000, 1'b0);
        send(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0);
        send(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0);
        send(32'h80000000, 32'h3F800000, 32'h80000000, 1'b0);
        idle(4);

        // Back-to-back random stream with a reset in the middle
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                rstn         = 1'b0;
                #1;
                check_eq("midrst_valid", {31'h0, bus.out_valid}, 32'h0);
                check_eq("midrst_y", bus.y, 32'h0);
                q.delete();
                repeat (2) @(negedge clk);
                rstn = 1'b1;
                idle(1);
            end
            ra = rand_fp();
            rb = rand_fp();
            ref_mul(ra, rb, ry, ro);
            send(ra, rb, ry, ro);
        end
        idle(6);
        check_eq("drain", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fmul_unit.md
Name: fmul_unit

Overview:
- Pipelined IEEE-754 binary32 multiplier for the FPU datapath.
- Computes y = x1 × x2 with round-to-nearest-even, full gradual-underflow (subnormal) support and IEEE special-value handling.
- Flags overflow separately; result bits match a reference single-precision host multiply bit-for-bit.
- Accepts one operation per cycle.

Parameters:
- none (binary32 format fixed: 1 sign, 8 exponent bits, bias 127, 23 fraction bits)

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  x1/x2 valid this cycle
- x1  input  32  operand A, binary32
- x2  input  32  operand B, binary32
- out_valid  output  1  y/ovf hold a new result
- y  output  32  product, binary32
- ovf  output  1  overflow: both operands finite, result is ±inf

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: out_valid=0, y=0, ovf=0, all pipeline valids cleared.
- Reset mid-operation drops in-flight results; no out_valid for them.
- Latency and throughput:
  - Latency exactly 2 cycles from an in_valid edge to out_valid.
  - Fully pipelined: back-to-back inputs give back-to-back outputs.
  - No backpressure.
  - y/ovf update only with out_valid and hold otherwise.
- Stage 1:
  - Unpack operands; implicit bit is 1 if exp≠0, else 0 with effective exp 1.
  - Classify each operand as zero / subnormal / normal / inf / NaN.
  - Sign = s1 XOR s2.
  - 24×24 significand product (48 bits); exponent sum e1+e2−127 computed in signed ≥10-bit width.
- Stage 2:
  - Normalise: left-shift by leading-zero count for subnormal inputs; 1-bit right adjust if product ≥2.
  - Underflow: if the normalised exponent < 1, right-shift significand by (1−exp) into guard/round/sticky; exponent field becomes 0.
  - Round to nearest, ties to even, using guard, round and sticky (OR of all discarded bits).
  - A rounding carry renormalises (a subnormal may round up to 0x00800000; 1.111… may round to the next binade).
  - If exponent ≥255 after rounding, y = sign,0xFF,0 and ovf=1.
- Specials, in priority order:
  - x1 NaN → x1 with fraction bit 22 set.
  - else x2 NaN → x2 with fraction bit 22 set.
  - inf×0 or 0×inf → 0xFFC00000.
  - inf×finite-nonzero or inf×inf → sign,0xFF,0.
  - zero×finite → sign,0,0 (signed zero).
- ovf is 0 whenever either input has exponent field 255, including NaN/inf results. A tiny result rounding to ±0 sets no flag.
- Sign is XOR in all non-NaN cases, including zero and inf results.

Decomposition:
- Shared package fpu_pkg:
  - Constants EXP_W=8, FRAC_W=23, BIAS=127, QNAN_DEFAULT=32'hFFC00000.
  - Typedef float32_t (packed struct sign/exp/frac).
  - Class enum {ZERO,SUB,NORM,INF,NAN}.
- One natural sub-module: fp_round_norm, the stage-2 normalise / underflow-shift / RNE round / overflow-detect logic. Reusable by fadd.
- Leading-zero count stays a function in fpu_pkg.

Test Plan:
- Basic products, latency check:
  - 0x3F800000×0x3F800000 → 0x3F800000, ovf=0, out_valid exactly 2 cycles after in_valid.
  - 0xBF800000×0x40000000 → 0xC0000000.
- Overflow:
  - 0x7F7FFFFF×0x40000000 → 0x7F800000, ovf=1.
  - 0xFF7FFFFF×0x7F7FFFFF → 0xFF800000, ovf=1.
- Specials:
  - 0x7F800000×0x3F800000 → 0x7F800000, ovf=0.
  - 0x7F800000×0x00000000 → 0xFFC00000, ovf=0.
  - 0x7FA00000×0x3F800000 → 0x7FE00000.
- Subnormals:
  - 0x00800000×0x3F000000 → 0x00400000.
  - 0x00000001×0x3F000000 → 0x00000000 (tie to even).
  - 0x00000001×0x3FC00000 → 0x00000002.
  - 0x00400000×0x40000000 → 0x00800000.
- Rounding:
  - 0x3F800001×0x3F800001 → 0x3F800002.
  - 0x3FFFFFFF×0x3FFFFFFF → 0x407FFFFE.
- Pipeline and reset:
  - Stream 1000 random pairs (all exponents 0..255, both signs) back-to-back; compare each against a host single-precision multiply, bit-exact, plus the ovf rule.
  - Assert rstn low mid-stream → out_valid=0 immediately; no stale results after release.
